// File: rtl/mux_nx1_blanked.sv
// Registered N:1 signed-sample mux. A channel change blanks the output for BLANK_CYCLES clocks.
// Define MUX_NX1_BLANKED_HOLD_EN to freeze the last sample during blanking instead of outputting 0.
module mux_nx1_blanked #(
  parameter int WIDTH        = 16,
  parameter int N_CH         = 4,
  parameter int SEL_WIDTH    = 2,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic [N_CH*WIDTH-1:0] in_i,
  output logic [WIDTH-1:0]      out_o,
  output logic [SEL_WIDTH-1:0]  sel_active_o,
  output logic                  busy_o,
  output logic                  switch_o
);

  localparam int NSEL = 2**SEL_WIDTH;
  localparam int CW   = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES+1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES-1) : '0;

  typedef enum logic {RUN, BLANK} state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] active, pending;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     chan [NSEL];
  logic [WIDTH-1:0]     blank_val;
  logic                 sel_valid;

  // Select codes past N_CH map to zero so any index into chan stays in range.
  for (genvar k = 0; k < NSEL; k++) begin : g_chan
    if (k < N_CH) begin : g_live
      assign chan[k] = in_i[k*WIDTH +: WIDTH];
    end else begin : g_dead
      assign chan[k] = '0;
    end
  end

  assign sel_valid    = (32'(sel_i) < 32'(N_CH));
  assign sel_active_o = active;

`ifdef MUX_NX1_BLANKED_HOLD_EN
  assign blank_val = out_o;
`else
  assign blank_val = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= RUN;
      active   <= '0;
      pending  <= '0;
      cnt      <= '0;
      out_o    <= '0;
      busy_o   <= 1'b0;
      switch_o <= 1'b0;
    end else begin
      switch_o <= 1'b0;
      case (state)
        RUN: begin
          if (sel_valid && sel_i != active) begin
            pending <= sel_i;
            if (BLANK_CYCLES == 0) begin
              active   <= sel_i;
              out_o    <= chan[sel_i];
              switch_o <= 1'b1;
            end else begin
              cnt    <= CNT_LOAD;
              out_o  <= blank_val;
              state  <= BLANK;
              busy_o <= 1'b1;
            end
          end else begin
            out_o <= chan[active];
          end
        end
        BLANK: begin
          // A fresh request restarts the interval even on what would be the terminal edge.
          if (sel_valid && sel_i != pending) begin
            pending <= sel_i;
            cnt     <= CNT_LOAD;
            out_o   <= blank_val;
          end else if (cnt == '0) begin
            active   <= pending;
            out_o    <= chan[pending];
            state    <= RUN;
            busy_o   <= 1'b0;
            switch_o <= 1'b1;
          end else begin
            cnt   <= cnt - CW'(1);
            out_o <= blank_val;
          end
        end
        default: begin
          state  <= RUN;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nx1_blanked.sv
// Bench for mux_nx1_blanked: three instances (4ch/B=8, 3ch/B=8, 4ch/B=0) on shared stimulus,
// checked every cycle against a remaining-blank-time model plus hand-computed literals.
module tb_mux_nx1_blanked;

  localparam int NDUT = 3;
  localparam int NCH [NDUT] = '{4, 3, 4};
  localparam int BL  [NDUT] = '{8, 8, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [63:0] in_bus = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  logic [15:0] d_out  [NDUT];
  logic [1:0]  d_act  [NDUT];
  logic        d_busy [NDUT];
  logic        d_sw   [NDUT];

  int nvec = 0;
  int nerr = 0;
  bit en = 1'b0;

  always #5 clk = ~clk;

  mux_nx1_blanked #(.WIDTH(16), .N_CH(4), .SEL_WIDTH(2), .BLANK_CYCLES(8)) u_main (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .in_i(in_bus),
    .out_o(d_out[0]), .sel_active_o(d_act[0]), .busy_o(d_busy[0]), .switch_o(d_sw[0]));

  mux_nx1_blanked #(.WIDTH(16), .N_CH(3), .SEL_WIDTH(2), .BLANK_CYCLES(8)) u_n3 (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .in_i(in_bus[47:0]),
    .out_o(d_out[1]), .sel_active_o(d_act[1]), .busy_o(d_busy[1]), .switch_o(d_sw[1]));

  mux_nx1_blanked #(.WIDTH(16), .N_CH(4), .SEL_WIDTH(2), .BLANK_CYCLES(0)) u_b0 (
    .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .in_i(in_bus),
    .out_o(d_out[2]), .sel_active_o(d_act[2]), .busy_o(d_busy[2]), .switch_o(d_sw[2]));

  // Model: left = blank cycles still to be shown; 0 means the active channel is live.
  int          m_active [NDUT] = '{0, 0, 0};
  int          m_pend   [NDUT] = '{0, 0, 0};
  int          m_left   [NDUT] = '{0, 0, 0};
  logic [15:0] m_out    [NDUT] = '{16'h0, 16'h0, 16'h0};
  logic        m_sw     [NDUT] = '{1'b0, 1'b0, 1'b0};
  int          ms;

  function automatic logic [15:0] chan(int k);
    return in_bus[k*16 +: 16];
  endfunction

  function automatic logic [15:0] blankv(logic [15:0] prev);
`ifdef MUX_NX1_BLANKED_HOLD_EN
    return prev;
`else
    return 16'h0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < NDUT; d++) begin
      if (!rst_n) begin
        m_active[d] = 0; m_pend[d] = 0; m_left[d] = 0; m_out[d] = 16'h0; m_sw[d] = 1'b0;
      end else begin
        ms = int'(sel);
        m_sw[d] = 1'b0;
        if (m_left[d] == 0) begin
          if (ms < NCH[d] && ms != m_active[d]) begin
            m_pend[d] = ms;
            if (BL[d] == 0) begin
              m_active[d] = ms; m_out[d] = chan(ms); m_sw[d] = 1'b1;
            end else begin
              m_left[d] = BL[d]; m_out[d] = blankv(m_out[d]);
            end
          end else begin
            m_out[d] = chan(m_active[d]);
          end
        end else if (ms < NCH[d] && ms != m_pend[d]) begin
          m_pend[d] = ms; m_left[d] = BL[d];
        end else begin
          m_left[d] = m_left[d] - 1;
          if (m_left[d] == 0) begin
            m_active[d] = m_pend[d]; m_out[d] = chan(m_pend[d]); m_sw[d] = 1'b1;
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL t=%0t dut%0d %s: got %h, expected %h", $time, d, nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      for (int d = 0; d < NDUT; d++) begin
        cmp("out", d, d_out[d], m_out[d]);
        cmp("sel_active", d, 16'(d_act[d]), 16'(m_active[d]));
        cmp("busy", d, 16'(d_busy[d]), 16'(m_left[d] > 0));
        cmp("switch", d, 16'(d_sw[d]), 16'(m_sw[d]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  logic [15:0] blank_main;
  logic [1:0]  b2b [8] = '{2'd2, 2'd1, 2'd3, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1};

  initial begin
    // Reset with channel data present
    tick(2);
    en = 1'b1;
    cmp("rst out", 0, d_out[0], 16'h0);
    cmp("rst sel_active", 0, 16'(d_act[0]), 16'h0);
    cmp("rst busy", 0, 16'(d_busy[0]), 16'h0);
    rst_n = 1'b1;
    tick(1);
    cmp("post-rst out", 0, d_out[0], 16'h1111);

    // Basic switch 0 -> 2
`ifdef MUX_NX1_BLANKED_HOLD_EN
    blank_main = 16'h1111;
`else
    blank_main = 16'h0;
`endif
    sel = 2'd2;
    tick(1);
    cmp("blank first out", 0, d_out[0], blank_main);
    cmp("blank first busy", 0, 16'(d_busy[0]), 16'h1);
    cmp("b0 immediate out", 2, d_out[2], 16'h3333);
    cmp("b0 immediate switch", 2, 16'(d_sw[2]), 16'h1);
    cmp("b0 never busy", 2, 16'(d_busy[2]), 16'h0);
    tick(7);
    cmp("blank last out", 0, d_out[0], blank_main);
    cmp("blank last busy", 0, 16'(d_busy[0]), 16'h1);
    tick(1);
    cmp("live out", 0, d_out[0], 16'h3333);
    cmp("live switch", 0, 16'(d_sw[0]), 16'h1);
    cmp("live sel_active", 0, 16'(d_act[0]), 16'h2);
    cmp("live busy", 0, 16'(d_busy[0]), 16'h0);
    tick(1);
    cmp("switch one cycle", 0, 16'(d_sw[0]), 16'h0);

    // RUN tracks new data with one cycle latency
    in_bus[47:32] = 16'h5555;
    tick(1);
    cmp("track out", 0, d_out[0], 16'h5555);

    // Retarget mid-blank: 1, then 3 four cycles later
    sel = 2'd1;
    tick(4);
    sel = 2'd3;
    tick(8);
    cmp("retarget busy", 0, 16'(d_busy[0]), 16'h1);
    cmp("retarget sel_active", 0, 16'(d_act[0]), 16'h2);
    tick(1);
    cmp("retarget out", 0, d_out[0], 16'h4444);
    cmp("retarget sel_active", 0, 16'(d_act[0]), 16'h3);
    cmp("retarget switch", 0, 16'(d_sw[0]), 16'h1);

    // Invalid select on the 3-channel instance (it settled on channel 1)
    tick(5);
    cmp("invalid busy", 1, 16'(d_busy[1]), 16'h0);
    cmp("invalid out", 1, d_out[1], 16'h2222);
    cmp("invalid sel_active", 1, 16'(d_act[1]), 16'h1);

    // Reset mid-blank
    sel = 2'd2;
    tick(3);
    cmp("pre-reset busy", 0, 16'(d_busy[0]), 16'h1);
`ifdef MUX_NX1_BLANKED_HOLD_EN
    cmp("hold out", 0, d_out[0], 16'h4444);
`else
    cmp("zero blank out", 0, d_out[0], 16'h0);
`endif
    rst_n = 1'b0;
    sel = 2'd0;
    tick(1);
    cmp("midblank rst out", 0, d_out[0], 16'h0);
    cmp("midblank rst busy", 0, 16'(d_busy[0]), 16'h0);
    cmp("midblank rst sel_active", 0, 16'(d_act[0]), 16'h0);
    rst_n = 1'b1;
    tick(2);
    cmp("after rst ch0", 0, d_out[0], 16'h1111);

    // Zero blanking 0 -> 1
    sel = 2'd1;
    tick(1);
    cmp("b0 0->1 out", 2, d_out[2], 16'h2222);
    cmp("b0 0->1 switch", 2, 16'(d_sw[2]), 16'h1);
    cmp("b0 0->1 busy", 2, 16'(d_busy[2]), 16'h0);

    // Back-to-back requests, then settle
    for (int i = 0; i < 8; i++) begin
      sel = b2b[i];
      tick(1);
    end
    tick(12);
    cmp("b2b final sel_active", 0, 16'(d_act[0]), 16'h1);
    cmp("b2b final out", 0, d_out[0], 16'h2222);

    // Held select produces no activity
    tick(4);
    cmp("held busy", 0, 16'(d_busy[0]), 16'h0);

    en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
